// File: rtl/lcd_bus_responder.sv
// Responder for an 8-bit HD44780-style LCD bus with a 32-cell display memory.
// Define LCD_RESP_READ_EN to enable status/data reads on the bus.
module lcd_bus_responder #(
    parameter int unsigned BUSY_CYCLES  = 40,
    parameter int unsigned CLEAR_CYCLES = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rw,
    input  logic       rs,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [4:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       disp_on,
    output logic       busy,
    output logic       err
);
    localparam int unsigned CntW = 16;

    typedef enum logic [1:0] {StIdle, StExec, StClear} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      ac_q, ac_d;
    logic            id_q, id_d;
    logic            disp_on_q, disp_on_d;
    logic            err_q, err_d;
    logic [7:0]      disp_char_q;

    logic       en_s1_q, en_s2_q, en_s3_q;
    logic       rw_s1_q, rw_s2_q;
    logic       rs_s1_q, rs_s2_q;
    logic [7:0] db_s1_q, db_s2_q;

    logic [7:0] mem [32];
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;

    logic       strobe;
    logic       wr_evt;
    logic [4:0] idx;

    assign strobe = en_s3_q & ~en_s2_q;
    assign wr_evt = strobe & ~rw_s2_q;
    assign idx    = {ac_q[6], ac_q[3:0]};
    assign busy   = (state_q != StIdle);

    // Line wrap: 0x0F <-> 0x40 and 0x4F <-> 0x00.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac[3:0] == 4'hF) return ac[6] ? 7'h00 : 7'h40;
            return ac + 7'd1;
        end
        if (ac[3:0] == 4'h0) return ac[6] ? 7'h0F : 7'h4F;
        return ac - 7'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ac_d      = ac_q;
        id_d      = id_q;
        disp_on_d = disp_on_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q[4:0];
        mem_wdata = 8'h20;

        unique case (state_q)
            StExec: begin
                if (cnt_q == CntW'(BUSY_CYCLES - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StClear: begin
                mem_we = (cnt_q < CntW'(32));
                if (cnt_q == CntW'(CLEAR_CYCLES + 31)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (wr_evt) begin
            if (busy) begin
                err_d = 1'b1;
            end else if (rs_s2_q) begin
                mem_we    = 1'b1;
                mem_waddr = idx;
                mem_wdata = db_s2_q;
                ac_d      = ac_step(ac_q, id_q);
                state_d   = StExec;
                cnt_d     = '0;
            end else if (db_s2_q == 8'h01) begin
                state_d = StClear;
                cnt_d   = '0;
                ac_d    = 7'h00;
                id_d    = 1'b1;
            end else if (db_s2_q != 8'h00) begin
                state_d = StExec;
                cnt_d   = '0;
                casez (db_s2_q)
                    8'b1???????: ac_d = {db_s2_q[6], 2'b00, db_s2_q[3:0]};
                    8'b00001???: disp_on_d = db_s2_q[2];
                    8'b000001??: id_d = db_s2_q[1];
                    8'b0000001?: ac_d = 7'h00;
                    default: ;
                endcase
            end
        end

`ifdef LCD_RESP_READ_EN
        if (strobe && rw_s2_q && rs_s2_q) ac_d = ac_step(ac_q, id_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StClear;
            cnt_q       <= '0;
            ac_q        <= 7'h00;
            id_q        <= 1'b1;
            disp_on_q   <= 1'b0;
            err_q       <= 1'b0;
            disp_char_q <= 8'h00;
            en_s1_q     <= 1'b0;
            en_s2_q     <= 1'b0;
            en_s3_q     <= 1'b0;
            rw_s1_q     <= 1'b0;
            rw_s2_q     <= 1'b0;
            rs_s1_q     <= 1'b0;
            rs_s2_q     <= 1'b0;
            db_s1_q     <= 8'h00;
            db_s2_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            disp_on_q   <= disp_on_d;
            err_q       <= err_d;
            disp_char_q <= mem[disp_addr];
            en_s1_q     <= en;
            en_s2_q     <= en_s1_q;
            en_s3_q     <= en_s2_q;
            rw_s1_q     <= rw;
            rw_s2_q     <= rw_s1_q;
            rs_s1_q     <= rs;
            rs_s2_q     <= rs_s1_q;
            db_s1_q     <= db_in;
            db_s2_q     <= db_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

`ifdef LCD_RESP_READ_EN
    logic [7:0] db_out_q;
    logic       db_oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_out_q <= 8'h00;
            db_oe_q  <= 1'b0;
        end else begin
            db_oe_q  <= en_s2_q & rw_s2_q;
            db_out_q <= (en_s2_q & rw_s2_q) ? (rs_s2_q ? mem[idx] : {busy, ac_q}) : 8'h00;
        end
    end

    assign db_out = db_out_q;
    assign db_oe  = db_oe_q;
`else
    assign db_out = 8'h00;
    assign db_oe  = 1'b0;
`endif

    assign disp_char = disp_char_q;
    assign disp_on   = disp_on_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed self-checking bench for lcd_bus_responder; expectations follow
// whether LCD_RESP_READ_EN is defined for the build.
module tb_lcd_bus_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rw = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] db_in = 8'h00;
    logic [7:0] db_out;
    logic       db_oe;
    logic [4:0] disp_addr = 5'd0;
    logic [7:0] disp_char;
    logic       disp_on;
    logic       busy;
    logic       err;

    int tests = 0;
    int fails = 0;

`ifdef LCD_RESP_READ_EN
    localparam bit ReadEn = 1'b1;
`else
    localparam bit ReadEn = 1'b0;
`endif

    lcd_bus_responder #(.BUSY_CYCLES(40), .CLEAR_CYCLES(1600)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rw        (rw),
        .rs        (rs),
        .db_in     (db_in),
        .db_out    (db_out),
        .db_oe     (db_oe),
        .disp_addr (disp_addr),
        .disp_char (disp_char),
        .disp_on   (disp_on),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic r_s, input logic [7:0] d);
        @(negedge clk);
        rw = 1'b0; rs = r_s; db_in = d; en = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_read(input logic r_s, output logic [7:0] d, output logic oe);
        @(negedge clk);
        rw = 1'b1; rs = r_s; en = 1'b1;
        repeat (5) @(negedge clk);
        d = db_out; oe = db_oe;
        en = 1'b0;
        repeat (5) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic get_cell(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk);
        disp_addr = a;
        @(posedge clk);
        @(negedge clk);
        v = disp_char;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic write_wait(input logic r_s, input logic [7:0] d);
        bus_write(r_s, d);
        wait_idle();
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] v;
        repeat (3) @(negedge clk);
        tests++;
        if ({db_out, db_oe, disp_char, disp_on, err, busy} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_outputs: db_out=%h oe=%b char=%h on=%b err=%b busy=%b, required 00 0 00 0 0 1",
                     db_out, db_oe, disp_char, disp_on, err, busy);
        end
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 3000);
        tests++;
        if (n !== 1632) begin
            fails++;
            $display("FAIL reset_busy_len: busy fell after %0d cycles, required 1632", n);
        end
        for (int i = 0; i < 32; i++) begin
            get_cell(5'(i), v);
            tests++;
            if (v !== 8'h20) begin
                fails++;
                $display("FAIL reset_cell%0d: got %h, required 20", i, v);
            end
        end
    endtask

    task automatic test_write_hi();
        logic [7:0] v, d;
        logic oe;
        write_wait(1'b0, 8'h80);
        write_wait(1'b1, 8'h48);
        write_wait(1'b1, 8'h49);
        get_cell(5'd0, v);
        tests++;
        if (v !== 8'h48) begin fails++; $display("FAIL hi_cell0: got %h, required 48", v); end
        get_cell(5'd1, v);
        tests++;
        if (v !== 8'h49) begin fails++; $display("FAIL hi_cell1: got %h, required 49", v); end
        bus_read(1'b0, d, oe);
        tests++;
        if ({oe, d} !== (ReadEn ? {1'b1, 8'h02} : {1'b0, 8'h00})) begin
            fails++;
            $display("FAIL hi_status: oe=%b db_out=%h, required oe=%b db_out=%h",
                     oe, d, ReadEn, ReadEn ? 8'h02 : 8'h00);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v, d;
        logic oe;
        write_wait(1'b0, 8'h8F);
        write_wait(1'b1, 8'h41);
        write_wait(1'b1, 8'h42);
        get_cell(5'd15, v);
        tests++;
        if (v !== 8'h41) begin fails++; $display("FAIL wrap_cell15: got %h, required 41", v); end
        get_cell(5'd16, v);
        tests++;
        if (v !== 8'h42) begin fails++; $display("FAIL wrap_cell16: got %h, required 42", v); end
        if (ReadEn) begin
            bus_read(1'b0, d, oe);
            tests++;
            if (d !== 8'h41) begin fails++; $display("FAIL wrap_ac41: got %h, required 41", d); end
        end
        write_wait(1'b0, 8'h04);
        write_wait(1'b0, 8'hC0);
        write_wait(1'b1, 8'h43);
        if (ReadEn) begin
            bus_read(1'b0, d, oe);
            tests++;
            if (d !== 8'h0F) begin fails++; $display("FAIL wrap_ac0f: got %h, required 0f", d); end
        end
        write_wait(1'b1, 8'h44);
        write_wait(1'b0, 8'h06);
        get_cell(5'd16, v);
        tests++;
        if (v !== 8'h43) begin fails++; $display("FAIL wrap_dec_cell16: got %h, required 43", v); end
        get_cell(5'd15, v);
        tests++;
        if (v !== 8'h44) begin fails++; $display("FAIL wrap_dec_cell15: got %h, required 44", v); end
    endtask

    task automatic test_read_path();
        logic [7:0] v, d;
        logic oe;
        write_wait(1'b0, 8'h81);
        bus_write(1'b1, 8'h32);
        bus_read(1'b0, d, oe);
        tests++;
        if ({oe, d} !== (ReadEn ? {1'b1, 8'h82} : {1'b0, 8'h00})) begin
            fails++;
            $display("FAIL read_busy_status: oe=%b db_out=%h, required oe=%b db_out=%h",
                     oe, d, ReadEn, ReadEn ? 8'h82 : 8'h00);
        end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL read_no_err: err=%b, required 0", err); end
        wait_idle();
        if (ReadEn) begin
            write_wait(1'b0, 8'h81);
            bus_read(1'b1, d, oe);
            tests++;
            if ({oe, d} !== {1'b1, 8'h32}) begin
                fails++;
                $display("FAIL read_data: oe=%b db_out=%h, required 1 32", oe, d);
            end
            bus_read(1'b0, d, oe);
            tests++;
            if (d !== 8'h02) begin fails++; $display("FAIL read_ac_step: got %h, required 02", d); end
        end else begin
            bus_read(1'b1, d, oe);
            tests++;
            if ({oe, d} !== 9'h000) begin
                fails++;
                $display("FAIL read_disabled: oe=%b db_out=%h, required 0 00", oe, d);
            end
        end
        write_wait(1'b1, 8'h33);
        get_cell(5'd2, v);
        tests++;
        if (v !== 8'h33) begin fails++; $display("FAIL read_cell2: got %h, required 33", v); end
    endtask

    task automatic test_busy_drop();
        logic [7:0] v;
        write_wait(1'b0, 8'h85);
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL drop_err_pre: err=%b, required 0", err); end
        bus_write(1'b1, 8'h55);
        bus_write(1'b1, 8'h66);
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL drop_err: err=%b, required 1", err); end
        wait_idle();
        get_cell(5'd5, v);
        tests++;
        if (v !== 8'h55) begin fails++; $display("FAIL drop_cell5: got %h, required 55", v); end
        get_cell(5'd6, v);
        tests++;
        if (v !== 8'h20) begin fails++; $display("FAIL drop_cell6: got %h, required 20", v); end
        write_wait(1'b1, 8'h77);
        get_cell(5'd6, v);
        tests++;
        if (v !== 8'h77) begin fails++; $display("FAIL drop_ac_kept: got %h, required 77", v); end
    endtask

    task automatic test_display_clear();
        logic [7:0] v, d;
        logic oe;
        write_wait(1'b0, 8'h0C);
        tests++;
        if (disp_on !== 1'b1) begin fails++; $display("FAIL disp_on: got %b, required 1", disp_on); end
        bus_write(1'b0, 8'h01);
        bus_read(1'b0, d, oe);
        tests++;
        if ({oe, d} !== (ReadEn ? {1'b1, 8'h80} : {1'b0, 8'h00})) begin
            fails++;
            $display("FAIL clear_status: oe=%b db_out=%h, required oe=%b db_out=%h",
                     oe, d, ReadEn, ReadEn ? 8'h80 : 8'h00);
        end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL clear_busy: got %b, required 1", busy); end
        wait_idle();
        for (int i = 0; i < 32; i++) begin
            get_cell(5'(i), v);
            tests++;
            if (v !== 8'h20) begin
                fails++;
                $display("FAIL clear_cell%0d: got %h, required 20", i, v);
            end
        end
        tests++;
        if ({err, disp_on} !== 2'b11) begin
            fails++;
            $display("FAIL clear_sticky: err=%b disp_on=%b, required 1 1", err, disp_on);
        end
        write_wait(1'b1, 8'h31);
        get_cell(5'd0, v);
        tests++;
        if (v !== 8'h31) begin fails++; $display("FAIL clear_ac0: got %h, required 31", v); end
    endtask

    initial begin
        test_reset();
        test_write_hi();
        test_wrap();
        test_read_path();
        test_busy_drop();
        test_display_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Synthesizable responder for the 8-bit HD44780-style character-LCD bus (en, rw, rs, db) that the Nios PIO core drives. It sits on the far end of that bus in place of, or alongside, the physical 2x16 module. It decodes command and data writes into a 32-character display memory and answers busy-flag and data reads. A second, synchronous read port exposes the display memory to local logic such as a mirror or on-screen renderer.

## Interface
- BUSY_CYCLES, 40: busy duration in clk cycles after any accepted write except clear.
- CLEAR_CYCLES, 1600: additional busy cycles after the 32-cell clear sweep.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  bus strobe; asynchronous to clk.
- rw  in  1  1 = read, 0 = write.
- rs  in  1  0 = instruction/status, 1 = data.
- db_in  in  8  bus data from the initiator.
- db_out  out  8  bus data returned on reads.
- db_oe  out  1  db_out drive enable.
- disp_addr  in  5  local read index; bit 4 selects the line, bits 3:0 select the column.
- disp_char  out  8  character at disp_addr, registered.
- disp_on  out  1  display-on bit (D).
- busy  out  1  busy flag.
- err  out  1  sticky flag: a write arrived while busy.

## Operation
- en, rw, rs and db_in pass through a 2-FF synchronizer. A strobe event is a falling edge of the synchronized en. At the event, rw, rs and db are taken from the same synchronized stage.
- Address counter (AC) is 7 bits. Legal values are 0x00-0x0F (line 1) and 0x40-0x4F (line 2). Memory index = {AC[6], AC[3:0]}.
- Increment order is 0x0F->0x40, 0x4F->0x00. Decrement order is the reverse: 0x00->0x4F, 0x40->0x0F.
- Entry mode bit I/D resets to 1 (increment).
- Instruction writes (rs=0, rw=0) are decoded by highest set bit:
  - 0x01 clear: enter CLEAR.
  - 0x02/0x03 home: AC=0.
  - 0x04-0x07 entry mode: I/D=db[1].
  - 0x08-0x0F display control: disp_on=db[2].
  - 0x10-0x3F: accepted, no effect.
  - 0x80+: AC=db[6:0] with bits 5:4 forced to 0.
  - 0x00: no effect and no busy period.
- Data write (rs=1, rw=0): mem[index]=db, then AC steps per I/D.
- Status read (rs=0, rw=1): db_out={busy, AC}. AC does not change.
- Data read (rs=1, rw=1): db_out=mem[index]. AC steps at the strobe event.
- Any write event while busy=1 is dropped and sets err. err is cleared only by reset.
- Reads are served regardless of busy.
- FSM states:
  - IDLE: accepts events. Any write other than 0x00 -> EXEC.
  - EXEC: counts BUSY_CYCLES, then -> IDLE.
  - CLEAR: writes 0x20 to indices 0..31, one per cycle. Sets AC=0 and I/D=1. Then counts CLEAR_CYCLES, then -> IDLE.
- busy=1 in EXEC and CLEAR.

## Timing
- Reset values:
  - Outputs: db_out=0x00, db_oe=0, disp_char=0x00, disp_on=0, err=0, busy=1.
  - Internal: AC=0, I/D=1.
- On reset release the FSM starts in CLEAR. Memory is all 0x20 after 32 cycles; busy falls 32+CLEAR_CYCLES cycles after reset release.
- Latency from a raw en fall to the strobe event is 3 clk.
- busy rises on the cycle after the strobe event.
- db_oe asserts 3 clk after a raw en rise with rw=1. It deasserts 3 clk after the raw en fall. db_out is valid on the same cycle db_oe asserts.
- The initiator holds en high at least 4 clk and low at least 4 clk. Shorter pulses are outside the supported range.
- disp_char has 1-cycle latency from disp_addr. During CLEAR it may read stale data.
- rst_n assertion mid-busy or mid-CLEAR aborts the operation immediately. The restart always re-runs CLEAR.

## Configuration
- LCD_RESP_READ_EN defined: status and data reads are supported as above.
- LCD_RESP_READ_EN undefined:
  - db_oe is constant 0 and db_out is constant 0x00.
  - rw=1 events are ignored: no AC step and no err.
  - The read-mux logic is removed.

## Test plan
- Reset release -> busy=1 for 32+CLEAR_CYCLES cycles, then 0. Every disp_addr 0..31 returns 0x20.
- Write 0x80, then data 'H' (0x48) and 'I' (0x49) -> disp_char@0=0x48, @1=0x49. Status read returns 0x02 after busy falls.
- Write 0x8F, data 0x41, data 0x42 -> index 15=0x41, index 16 (AC 0x40)=0x42, AC=0x41. Then entry mode 0x04, set 0xC0, data 0x43 -> AC=0x0F.
- Data write, then a second data write 5 clk later (busy) -> second write dropped, err=1, memory and AC unchanged by it.
- Write 0x0C -> disp_on=1. Write 0x01 -> all cells 0x20, AC=0. Status read during clear returns bit7=1 with db_oe=1 (read build).
- Build without LCD_RESP_READ_EN: status read with rs=0, rw=1 -> db_oe stays 0, AC and err unchanged.
